bist_ctrl_param: RTL

Parametrised logic-BIST controller for multi-chain scan designs; successor to the single-chain BIST top.
- Drives N_CHAINS scan chains of the circuit under test (CUT) from an LFSR pattern generator (PRPG).
- Sequences shift and capture for N_PATTERNS patterns.
- Compacts the CUT scan outputs into a MISR and compares the final signature against a golden value.
- Sits between the chip-level BIST start/end pins and the CUT scan ports.

---
 rtl/bist_ctrl_param_if.sv | 29 ++
 rtl/bist_ctrl_param.sv | 137 +++++++++++++
 2 files changed

// File: rtl/bist_ctrl_param_if.sv
// Chip-side BIST handshake plus the scan-port bundle between the controller and the CUT.
// The master side is the controller. The slave side is the chip pins and the CUT scan ports.
interface bist_ctrl_param_if #(
    parameter int N_CHAINS   = 4,
    parameter int MISR_W     = 16,
    parameter int N_PATTERNS = 100
);
    localparam int PC_W = $clog2(N_PATTERNS + 1);

    logic                bist_start;
    logic                scan_en;
    logic [N_CHAINS-1:0] scan_in;
    logic [N_CHAINS-1:0] scan_out;
    logic                busy;
    logic                bist_end;
    logic                pass_fail;
    logic [MISR_W-1:0]   signature;
    logic [PC_W-1:0]     pattern_cnt;

    modport master (
        input  bist_start, scan_out,
        output scan_en, scan_in, busy, bist_end, pass_fail, signature, pattern_cnt
    );

    modport slave (
        output bist_start, scan_out,
        input  scan_en, scan_in, busy, bist_end, pass_fail, signature, pattern_cnt
    );
endinterface

// File: rtl/bist_ctrl_param.sv
// Multi-chain logic-BIST controller.
// An LFSR pattern generator feeds N_CHAINS scan chains. The controller shifts and captures
// N_PATTERNS patterns, compacts the chain tails into a MISR, and checks the final signature
// against GOLDEN_SIG.
module bist_ctrl_param #(
    parameter int                 N_CHAINS   = 4,
    parameter int                 CHAIN_LEN  = 16,
    parameter int                 N_PATTERNS = 100,
    parameter int                 LFSR_W     = 16,
    parameter logic [LFSR_W-1:0]  LFSR_POLY  = 16'h002D,
    parameter logic [LFSR_W-1:0]  LFSR_SEED  = 16'hACE1,
    parameter int                 MISR_W     = 16,
    parameter logic [MISR_W-1:0]  MISR_POLY  = 16'h1021,
    parameter logic [MISR_W-1:0]  GOLDEN_SIG = 16'h0000
) (
    input  logic                   CLK,
    input  logic                   RST,
    bist_ctrl_param_if.master      bus
);
    localparam int SH_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int PC_W = $clog2(N_PATTERNS + 1);
    localparam logic [SH_W-1:0] SH_LAST = SH_W'(CHAIN_LEN - 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(N_PATTERNS - 1);

    typedef enum logic [2:0] {
        IDLE, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [LFSR_W-1:0] lfsr;
    logic [MISR_W-1:0] misr;
    logic [SH_W-1:0]   sh_cnt;
    logic [PC_W-1:0]   pat_cnt;
    logic              match;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        lfsr_step = (v << 1) ^ (v[LFSR_W-1] ? LFSR_POLY : '0);
    endfunction

    function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] m,
                                                    input logic [N_CHAINS-1:0] so);
        logic [MISR_W-1:0] ext;
        ext = '0;
        ext[N_CHAINS-1:0] = so;
        misr_step = (m << 1) ^ (m[MISR_W-1] ? MISR_POLY : '0) ^ ext;
    endfunction

    // State register. Reset wins over everything, including a run in progress.
    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state logic and outputs decoded from the registered state (no input-to-output path).
    always_comb begin
        state_nx      = state;
        bus.scan_en   = 1'b0;
        bus.scan_in   = '0;
        bus.busy      = 1'b0;
        bus.bist_end  = 1'b0;
        bus.pass_fail = 1'b0;
        case (state)
            IDLE: begin
                if (bus.bist_start) state_nx = SHIFT;
            end
            SHIFT: begin
                bus.scan_en = 1'b1;
                bus.scan_in = lfsr[N_CHAINS-1:0];
                bus.busy    = 1'b1;
                if (sh_cnt == SH_LAST) state_nx = CAPTURE;
            end
            CAPTURE: begin
                bus.busy = 1'b1;
                state_nx = (pat_cnt == PC_LAST) ? UNLOAD : SHIFT;
            end
            UNLOAD: begin
                bus.scan_en = 1'b1;
                bus.busy    = 1'b1;
                if (sh_cnt == SH_LAST) state_nx = COMPARE;
            end
            COMPARE: begin
                bus.busy = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                bus.bist_end  = 1'b1;
                bus.pass_fail = match;
                if (!bus.bist_start) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Pattern generator, compactor, counters and the match flag. The first unload is
    // masked because the chains still hold power-up state at that point.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            lfsr    <= LFSR_SEED;
            misr    <= '0;
            sh_cnt  <= '0;
            pat_cnt <= '0;
            match   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.bist_start) begin
                        lfsr    <= LFSR_SEED;
                        misr    <= '0;
                        sh_cnt  <= '0;
                        pat_cnt <= '0;
                        match   <= 1'b0;
                    end
                end
                SHIFT: begin
                    lfsr   <= lfsr_step(lfsr);
                    sh_cnt <= (sh_cnt == SH_LAST) ? '0 : sh_cnt + SH_W'(1);
                    if (pat_cnt != '0) misr <= misr_step(misr, bus.scan_out);
                end
                CAPTURE: begin
                    pat_cnt <= pat_cnt + PC_W'(1);
                end
                UNLOAD: begin
                    misr   <= misr_step(misr, bus.scan_out);
                    sh_cnt <= (sh_cnt == SH_LAST) ? '0 : sh_cnt + SH_W'(1);
                end
                COMPARE: begin
                    match <= (misr == GOLDEN_SIG);
                end
                default: ;
            endcase
        end
    end

    assign bus.signature   = misr;
    assign bus.pattern_cnt = pat_cnt;
endmodule
